// File: rtl/multirate_counter.sv
// Up/down modulo-(MAX+1) counter stepped at a selectable rate derived from CLOCK_50.
// Any load, pause or rate change restarts the rate divider from its full terminal count.
module multirate_counter #(
  parameter int CLK_HZ = 50000000,
  parameter int WIDTH  = 4,
  parameter int MAX    = 15,
  parameter int DIV_W  = 28
) (
  input  logic             CLOCK_50,
  input  logic             Reset,
  input  logic             run,
  input  logic [1:0]       sel,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [DIV_W-1:0] term_tbl [4];
  logic [DIV_W-1:0] term;

  logic [WIDTH-1:0] count_reg, count_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [1:0]       sel_q_reg;
  logic             tick_reg, tick_next;
  logic             wrap_reg, wrap_next;

  // Terminal counts: sel 0 steps every clock, sel n>0 waits CLK_HZ*2^(n-1) clocks.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_term
      if (gi == 0) begin : g_every
        assign term_tbl[gi] = '0;
      end else begin : g_slow
        assign term_tbl[gi] = DIV_W'(CLK_HZ * (1 << (gi - 1)) - 1);
      end
    end
  endgenerate

  assign term = term_tbl[sel];

  always_comb begin
    count_next = count_reg;
    div_next   = div_reg - DIV_W'(1);
    tick_next  = 1'b0;
    wrap_next  = 1'b0;
    if (load) begin
      count_next = (load_val > MAX_V) ? MAX_V : load_val;
      div_next   = term;
    end else if (!run || (sel != sel_q_reg)) begin
      div_next = term;
    end else if (div_reg == '0) begin
      div_next  = term;
      tick_next = 1'b1;
      if (up) begin
        if (count_reg == MAX_V) begin
          count_next = '0;
          wrap_next  = 1'b1;
        end else begin
          count_next = count_reg + WIDTH'(1);
        end
      end else begin
        if (count_reg == '0) begin
          count_next = MAX_V;
          wrap_next  = 1'b1;
        end else begin
          count_next = count_reg - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      count_reg <= '0;
      div_reg   <= '0;
      sel_q_reg <= 2'b00;
      tick_reg  <= 1'b0;
      wrap_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      div_reg   <= div_next;
      sel_q_reg <= sel;
      tick_reg  <= tick_next;
      wrap_reg  <= wrap_next;
    end
  end

  assign count = count_reg;
  assign tick  = tick_reg;
  assign wrap  = wrap_reg;

endmodule

// File: tb/tb_multirate_counter.sv
// Self-checking bench for multirate_counter: directed scenarios plus randomized traffic
// checked against an edge-index scheduling model of the counter.
module tb_multirate_counter;
  localparam int CLK_HZ = 4;
  localparam int WIDTH  = 4;
  localparam int MAX    = 9;
  localparam int DIV_W  = 5;

  logic             CLOCK_50 = 1'b0;
  logic             Reset    = 1'b0;
  logic             run      = 1'b0;
  logic [1:0]       sel      = 2'b00;
  logic             up       = 1'b1;
  logic             load     = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             wrap;

  int tests = 0;
  int fails = 0;

  // Model: each restart schedules the next step one full period (in edges) ahead.
  int         edge_n   = 0;
  int         next_due = 1;
  int         m_count  = 0;
  logic       m_tick   = 1'b0;
  logic       m_wrap   = 1'b0;
  logic [1:0] m_prev_sel = 2'b00;

  multirate_counter #(
    .CLK_HZ(CLK_HZ), .WIDTH(WIDTH), .MAX(MAX), .DIV_W(DIV_W)
  ) dut (
    .CLOCK_50(CLOCK_50), .Reset(Reset), .run(run), .sel(sel), .up(up),
    .load(load), .load_val(load_val), .count(count), .tick(tick), .wrap(wrap)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic int period(input logic [1:0] s);
    case (s)
      2'b00:   return 1;
      2'b01:   return CLK_HZ;
      2'b10:   return 2 * CLK_HZ;
      default: return 4 * CLK_HZ;
    endcase
  endfunction

  task automatic model_reset();
    m_count    = 0;
    m_tick     = 1'b0;
    m_wrap     = 1'b0;
    m_prev_sel = 2'b00;
    next_due   = edge_n + 1;
  endtask

  task automatic advance();
    @(posedge CLOCK_50);
    edge_n++;
    m_tick = 1'b0;
    m_wrap = 1'b0;
    if (load) begin
      m_count  = (int'(load_val) > MAX) ? MAX : int'(load_val);
      next_due = edge_n + period(sel);
    end else if (!run || sel != m_prev_sel) begin
      next_due = edge_n + period(sel);
    end else if (edge_n == next_due) begin
      m_tick = 1'b1;
      if (up) begin
        m_wrap  = (m_count == MAX);
        m_count = (m_count + 1) % (MAX + 1);
      end else begin
        m_wrap  = (m_count == 0);
        m_count = (m_count + MAX) % (MAX + 1);
      end
      next_due = edge_n + period(sel);
    end
    m_prev_sel = sel;
    #1;
  endtask

  // Short reset pulse placed between clock edges.
  task automatic reset_dut();
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    #1;
    Reset = 1'b1;
    #1;
    tests++;
    if (count !== 4'd0 || tick !== 1'b0 || wrap !== 1'b0) begin
      fails++;
      $display("FAIL reset_async: count=%0d tick=%b wrap=%b, required 0/0/0", count, tick, wrap);
    end
    run = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge CLOCK_50);
      #1;
      tests++;
      if (count !== 4'd0 || tick !== 1'b0 || wrap !== 1'b0) begin
        fails++;
        $display("FAIL reset_held: count=%0d tick=%b wrap=%b, required 0/0/0", count, tick, wrap);
      end
    end
    run = 1'b0;
    Reset = 1'b0;
    model_reset();
    $display("[TB] test_reset done");
  endtask

  task automatic test_every_clock();
    int exp_c;
    sel = 2'b00; up = 1'b1; run = 1'b1;
    reset_dut();
    for (int i = 1; i <= 12; i++) begin
      advance();
      exp_c = i % (MAX + 1);
      tests++;
      if (count !== 4'(exp_c) || tick !== 1'b1 || wrap !== 1'(exp_c == 0)) begin
        fails++;
        $display("FAIL every_clock edge %0d: count=%0d tick=%b wrap=%b, required %0d/1/%b",
                 i, count, tick, wrap, exp_c, exp_c == 0);
      end
    end
    $display("[TB] test_every_clock done, count=%0d", count);
  endtask

  task automatic test_one_hz();
    int   ticks = 0;
    logic exp_t;
    sel = 2'b01; up = 1'b1; run = 1'b1;
    reset_dut();
    for (int e = 1; e <= 17; e++) begin
      advance();
      exp_t = (e >= 5) && ((e - 5) % 4 == 0);
      if (exp_t) ticks++;
      tests++;
      if (tick !== exp_t || count !== 4'(ticks) || wrap !== 1'b0) begin
        fails++;
        $display("FAIL one_hz edge %0d: count=%0d tick=%b wrap=%b, required %0d/%b/0",
                 e, count, tick, wrap, ticks, exp_t);
      end
    end
    $display("[TB] test_one_hz done, ticks=%0d", ticks);
  endtask

  task automatic test_slow_down();
    int   exp_c;
    logic exp_t, exp_w;
    sel = 2'b11; up = 1'b0; run = 1'b1;
    reset_dut();
    for (int e = 1; e <= 33; e++) begin
      advance();
      exp_c = (e < 17) ? 0 : ((e < 33) ? 9 : 8);
      exp_t = (e == 17) || (e == 33);
      exp_w = (e == 17);
      tests++;
      if (count !== 4'(exp_c) || tick !== exp_t || wrap !== exp_w) begin
        fails++;
        $display("FAIL slow_down edge %0d: count=%0d tick=%b wrap=%b, required %0d/%b/%b",
                 e, count, tick, wrap, exp_c, exp_t, exp_w);
      end
    end
    $display("[TB] test_slow_down done, count=%0d", count);
  endtask

  task automatic test_load_clamp();
    sel = 2'b01; up = 1'b1; run = 1'b1;
    reset_dut();
    for (int e = 1; e <= 12; e++) advance();
    load = 1'b1; load_val = 4'd12;
    advance();
    load = 1'b0;
    tests++;
    if (count !== 4'd9 || tick !== 1'b0 || wrap !== 1'b0) begin
      fails++;
      $display("FAIL load_clamp: count=%0d tick=%b wrap=%b, required 9/0/0", count, tick, wrap);
    end
    for (int k = 1; k <= 4; k++) begin
      advance();
      tests++;
      if (tick !== 1'(k == 4) || wrap !== 1'(k == 4) || count !== ((k == 4) ? 4'd0 : 4'd9)) begin
        fails++;
        $display("FAIL load_next_step k=%0d: count=%0d tick=%b wrap=%b, required %0d/%b/%b",
                 k, count, tick, wrap, (k == 4) ? 0 : 9, k == 4, k == 4);
      end
    end
    $display("[TB] test_load_clamp done");
  endtask

  task automatic test_pause();
    int gap = 0;
    sel = 2'b10; up = 1'b1; run = 1'b1;
    reset_dut();
    for (int e = 1; e <= 20; e++) advance();
    run = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      advance();
      tests++;
      if (count !== 4'd2 || tick !== 1'b0) begin
        fails++;
        $display("FAIL pause_frozen k=%0d: count=%0d tick=%b, required 2/0", k, count, tick);
      end
    end
    run = 1'b1;
    for (int k = 1; k <= 12 && gap == 0; k++) begin
      advance();
      if (tick === 1'b1) gap = k;
    end
    tests++;
    if (gap != 8 || count !== 4'd3) begin
      fails++;
      $display("FAIL pause_resume: gap=%0d count=%0d, required gap 8 count 3", gap, count);
    end
    $display("[TB] test_pause done, gap=%0d", gap);
  endtask

  task automatic test_async_reset();
    sel = 2'b00; up = 1'b1; run = 1'b1;
    reset_dut();
    for (int e = 1; e <= 5; e++) advance();
    #3;
    Reset = 1'b1;
    #1;
    tests++;
    if (count !== 4'd0 || tick !== 1'b0 || wrap !== 1'b0) begin
      fails++;
      $display("FAIL async_reset_mid: count=%0d tick=%b wrap=%b, required 0/0/0", count, tick, wrap);
    end
    #1;
    Reset = 1'b0;
    model_reset();
    advance();
    tests++;
    if (count !== 4'd1 || tick !== 1'b1 || wrap !== 1'b0) begin
      fails++;
      $display("FAIL async_reset_resume: count=%0d tick=%b wrap=%b, required 1/1/0", count, tick, wrap);
    end
    $display("[TB] test_async_reset done");
  endtask

  task automatic test_random();
    sel = 2'($urandom_range(0, 3)); run = 1'b1; up = 1'($urandom_range(0, 1));
    reset_dut();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) up = ~up;
      run      = ($urandom_range(0, 9) != 0);
      load     = ($urandom_range(0, 49) == 0);
      load_val = 4'($urandom_range(0, 15));
      advance();
      if (load) $display("[TB] random edge %0d load %0d -> count=%0d", edge_n, load_val, count);
      tests++;
      if (count !== 4'(m_count) || tick !== m_tick || wrap !== m_wrap || int'(count) > MAX) begin
        fails++;
        $display("FAIL random edge %0d: count=%0d tick=%b wrap=%b, required %0d/%b/%b",
                 edge_n, count, tick, wrap, m_count, m_tick, m_wrap);
      end
    end
    load = 1'b0;
    $display("[TB] test_random done");
  endtask

  initial begin
    test_reset();
    test_every_clock();
    test_one_hz();
    test_slow_down();
    test_load_clamp();
    test_pause();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
